// File: rtl/elevator_door_controller.sv
// Elevator car door sequencer: CLOSED -> OPENING -> OPEN -> CLOSING.
// One clk cycle is one timing tick from the upstream frequency divider.
// The door reopens fully on obstruction or an open request while closing.
// A sticky interlock fault is raised if the car moves with the door not closed.
`timescale 1ns/1ps

module elevator_door_controller #(
  parameter int OPEN_TIME    = 5,
  parameter int TRANSIT_TIME = 2,
  parameter int TIMER_W      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               open_req,
  input  logic               close_req,
  input  logic               obstruction,
  input  logic               moving,
  output logic [1:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic               door_closed,
  output logic               door_open,
  output logic               door_busy,
  output logic               fault
);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } door_state_e;

  // Reload values: a state lasts exactly its duration because the exit
  // happens on the cycle the timer is already at zero.
  localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_TIME - 1);
  localparam logic [TIMER_W-1:0] TRANSIT_LOAD = TIMER_W'(TRANSIT_TIME - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO   = {TIMER_W{1'b0}};
  localparam logic [TIMER_W-1:0] TIMER_ONE    = TIMER_W'(1);

  door_state_e        state_r;
  door_state_e        next_state_s;
  logic [TIMER_W-1:0] timer_r;
  logic [TIMER_W-1:0] next_timer_s;
  logic               fault_r;
  logic               door_closed_r;
  logic               door_open_r;
  logic               door_busy_r;
  logic               timer_done_s;
  logic               reopen_s;

  assign timer_done_s = (timer_r == TIMER_ZERO);
  assign reopen_s     = obstruction | open_req;

  // Next-state and timer reload/decrement decision for the door sequence.
  always_comb begin
    next_state_s = state_r;
    next_timer_s = timer_r;
    case (state_r)
      ST_CLOSED: begin
        // A request while the car is moving is dropped, not remembered.
        if (open_req && !moving) begin
          next_state_s = ST_OPENING;
          next_timer_s = TRANSIT_LOAD;
        end else begin
          next_state_s = ST_CLOSED;
          next_timer_s = TIMER_ZERO;
        end
      end
      ST_OPENING: begin
        // Door mechanics are committed once opening starts; inputs ignored.
        if (timer_done_s) begin
          next_state_s = ST_OPEN;
          next_timer_s = OPEN_LOAD;
        end else begin
          next_state_s = ST_OPENING;
          next_timer_s = timer_r - TIMER_ONE;
        end
      end
      ST_OPEN: begin
        // Holding the door (obstruction or request) wins over an early close.
        if (reopen_s) begin
          next_state_s = ST_OPEN;
          next_timer_s = OPEN_LOAD;
        end else if (close_req || timer_done_s) begin
          next_state_s = ST_CLOSING;
          next_timer_s = TRANSIT_LOAD;
        end else begin
          next_state_s = ST_OPEN;
          next_timer_s = timer_r - TIMER_ONE;
        end
      end
      ST_CLOSING: begin
        // Reopen restarts the full opening transit; no credit for progress.
        if (reopen_s) begin
          next_state_s = ST_OPENING;
          next_timer_s = TRANSIT_LOAD;
        end else if (timer_done_s) begin
          next_state_s = ST_CLOSED;
          next_timer_s = TIMER_ZERO;
        end else begin
          next_state_s = ST_CLOSING;
          next_timer_s = timer_r - TIMER_ONE;
        end
      end
      default: begin
        next_state_s = ST_CLOSED;
        next_timer_s = TIMER_ZERO;
      end
    endcase
  end

  // State, timer, sticky fault and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_CLOSED;
      timer_r       <= TIMER_ZERO;
      fault_r       <= 1'b0;
      door_closed_r <= 1'b1;
      door_open_r   <= 1'b0;
      door_busy_r   <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      timer_r       <= next_timer_s;
      // Interlock looks at the door state present when the car moves.
      fault_r       <= fault_r | (moving & (state_r != ST_CLOSED));
      door_closed_r <= (next_state_s == ST_CLOSED);
      door_open_r   <= (next_state_s == ST_OPEN);
      door_busy_r   <= (next_state_s == ST_OPENING) | (next_state_s == ST_CLOSING);
    end
  end

  assign state       = state_r;
  assign timer       = timer_r;
  assign fault       = fault_r;
  assign door_closed = door_closed_r;
  assign door_open   = door_open_r;
  assign door_busy   = door_busy_r;

endmodule

// File: tb/tb_elevator_door_controller.sv
// Directed self-checking bench for elevator_door_controller
// (OPEN_TIME=5, TRANSIT_TIME=2, TIMER_W=4).
`timescale 1ns/1ps

module tb_elevator_door_controller;

  logic       clk;
  logic       rst_n;
  logic       open_req;
  logic       close_req;
  logic       obstruction;
  logic       moving;
  logic [1:0] state;
  logic [3:0] timer;
  logic       door_closed;
  logic       door_open;
  logic       door_busy;
  logic       fault;

  int errors;
  int checks;

  elevator_door_controller #(
    .OPEN_TIME   (5),
    .TRANSIT_TIME(2),
    .TIMER_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .open_req   (open_req),
    .close_req  (close_req),
    .obstruction(obstruction),
    .moving     (moving),
    .state      (state),
    .timer      (timer),
    .door_closed(door_closed),
    .door_open  (door_open),
    .door_busy  (door_busy),
    .fault      (fault)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks = checks + 1;
    if (obs != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one posedge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // State, timer and the three decoded status flags.
  task automatic expect_door(input string tag, input int st, input int tm);
    check({tag, ".state"}, int'(state), st);
    check({tag, ".timer"}, int'(timer), tm);
    check({tag, ".closed"}, int'(door_closed), (st == 0) ? 1 : 0);
    check({tag, ".open"}, int'(door_open), (st == 2) ? 1 : 0);
    check({tag, ".busy"}, int'(door_busy), (st == 1 || st == 3) ? 1 : 0);
  endtask

  // Expected trace of the full open/close cycle, one entry per edge 0..9.
  int fc_state [10] = '{1, 1, 2, 2, 2, 2, 2, 3, 3, 0};
  int fc_timer [10] = '{1, 0, 4, 3, 2, 1, 0, 1, 0, 0};
  int ob_timer [4]  = '{3, 2, 1, 0};

  initial begin
    errors      = 0;
    checks      = 0;
    rst_n       = 1'b0;
    open_req    = 1'b1;
    close_req   = 1'b1;
    obstruction = 1'b1;
    moving      = 1'b1;

    // Reset with every input asserted.
    tick();
    tick();
    expect_door("reset", 0, 0);
    check("reset.fault", int'(fault), 0);

    rst_n       = 1'b1;
    open_req    = 1'b0;
    close_req   = 1'b0;
    obstruction = 1'b0;
    moving      = 1'b0;
    tick();
    expect_door("idle", 0, 0);

    // Full cycle from a one-cycle open request.
    open_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      open_req = 1'b0;
      expect_door($sformatf("full.e%0d", i), fc_state[i], fc_timer[i]);
    end

    // Moving blocks the request in CLOSED and never faults there.
    moving   = 1'b1;
    open_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lock.state%0d", i), int'(state), 0);
      check($sformatf("lock.fault%0d", i), int'(fault), 0);
    end
    moving   = 1'b0;
    open_req = 1'b0;
    tick();
    expect_door("lock.notlatched", 0, 0);

    // Open the door, then move the car while it is open.
    open_req = 1'b1;
    tick();
    open_req = 1'b0;
    expect_door("lock.opening", 1, 1);
    tick();
    tick();
    expect_door("lock.open", 2, 4);
    check("lock.prefault", int'(fault), 0);
    moving = 1'b1;
    tick();
    moving = 1'b0;
    check("fault.set", int'(fault), 1);
    expect_door("fault.nochange", 2, 3);
    tick();
    check("fault.sticky", int'(fault), 1);
    expect_door("open.t2", 2, 2);
    tick();
    expect_door("open.t1", 2, 1);

    // Obstruction at timer=1 reloads the dwell.
    obstruction = 1'b1;
    tick();
    obstruction = 1'b0;
    expect_door("obst.reload", 2, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_door($sformatf("obst.e%0d", i + 1), 2, ob_timer[i]);
    end
    tick();
    expect_door("obst.closing", 3, 1);

    // Obstruction in the first CLOSING cycle reopens fully.
    obstruction = 1'b1;
    tick();
    obstruction = 1'b0;
    expect_door("reopen.opening", 1, 1);
    tick();
    expect_door("reopen.t0", 1, 0);
    tick();
    expect_door("reopen.open", 2, 4);

    // Open request beats close request while open.
    open_req  = 1'b1;
    close_req = 1'b1;
    tick();
    open_req  = 1'b0;
    close_req = 1'b0;
    expect_door("prio.hold", 2, 4);
    tick();
    expect_door("early.t3", 2, 3);

    // Early close at timer=3.
    close_req = 1'b1;
    tick();
    close_req = 1'b0;
    expect_door("early.closing", 3, 1);

    // Reset mid-transit clears state, timer and fault.
    rst_n = 1'b0;
    tick();
    expect_door("midrst", 0, 0);
    check("midrst.fault", int'(fault), 0);
    rst_n = 1'b1;
    tick();
    expect_door("midrst.idle", 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elevator_door_controller.md
Name: elevator_door_controller

Overview:
- Door state machine for the elevator car, directly downstream of frequency_divisor.
- Clocked by the divided `clk` that frequency_divisor produces, so one clock cycle is one timing tick.
- Sequences the door through closed, opening, open and closing; times dwell and transit in ticks; handles reopen on obstruction.
- Flags a fault if the car moves while the door is not closed.

Parameters:
- OPEN_TIME, 5: ticks the door dwells fully open; must be >= 1.
- TRANSIT_TIME, 2: ticks to fully open or fully close; must be >= 1.
- TIMER_W, 4: timer width; must hold max(OPEN_TIME, TRANSIT_TIME) - 1.

Ports:
- clk  input  1: divided clock from frequency_divisor; all logic on posedge.
- rst_n  input  1: reset, synchronous, active-low.
- open_req  input  1: level, request the door to open or hold open.
- close_req  input  1: level, request early close while open.
- obstruction  input  1: level, object in the doorway.
- moving  input  1: level, car in motion.
- state  output  2: 0=CLOSED, 1=OPENING, 2=OPEN, 3=CLOSING.
- timer  output  TIMER_W: remaining-tick down-counter.
- door_closed  output  1: high iff state==CLOSED.
- door_open  output  1: high iff state==OPEN.
- door_busy  output  1: high iff state is OPENING or CLOSING.
- fault  output  1: sticky interlock violation.

Behaviour:
- Interface: one clock (`clk`). Reset (`rst_n`) is synchronous and active-low.
- Output timing: all outputs come from registers or are decoded from the state register only. There is no combinational path from any input to any output.
- Reset (rst_n==0 at posedge clk): state=CLOSED, timer=0, fault=0, door_closed=1, door_open=0, door_busy=0. Reset overrides any state, including mid-transit.
- Timer rule: when a state is entered, timer loads its duration minus 1.
  - Each cycle in that state, if timer!=0 the timer decrements; if timer==0 the state exits.
  - Result: a state lasts exactly its duration in cycles.
  - Timer never wraps below 0.
- CLOSED:
  - open_req && !moving -> OPENING, timer=TRANSIT_TIME-1.
  - Otherwise stay, timer=0.
  - open_req while moving is ignored; it is not latched.
- OPENING: timer==0 -> OPEN, timer=OPEN_TIME-1. Inputs are ignored while opening.
- OPEN, in priority order:
  1. obstruction || open_req -> stay, timer reloads OPEN_TIME-1.
  2. Else close_req -> CLOSING, timer=TRANSIT_TIME-1.
  3. Else timer==0 -> CLOSING, timer=TRANSIT_TIME-1.
  4. Else decrement.
- CLOSING:
  - obstruction || open_req -> OPENING, timer=TRANSIT_TIME-1 (full reopen; no partial credit).
  - Else timer==0 -> CLOSED, timer=0.
  - Else decrement.
- Fault:
  - fault is set on any posedge where moving==1 and state!=CLOSED.
  - It stays set until reset.
  - It does not alter FSM transitions.
- Simultaneous inputs:
  - In CLOSED, moving blocks open_req.
  - In OPEN, obstruction or open_req beats close_req.
  - In CLOSING, a reopen request beats completing the close on the same edge.
- Unused encodings: none; all four states are legal.

Test Plan:
All scenarios use OPEN_TIME=5, TRANSIT_TIME=2, TIMER_W=4. "Edge n" counts posedges after the stimulus edge (edge 0).
- Reset: hold rst_n=0 for 2 cycles with all inputs high -> state=0, timer=0, door_closed=1, door_open=0, door_busy=0, fault=0.
- Full cycle: pulse open_req for 1 cycle at edge 0 -> state values after each edge:
  - After edges 0-1: OPENING (timer 1, then 0).
  - After edges 2-6: OPEN (timer 4, 3, 2, 1, 0).
  - After edges 7-8: CLOSING.
  - After edge 9: CLOSED, door_closed=1.
- Interlock: moving=1 with open_req=1 held in CLOSED for 10 cycles -> state stays 0, fault stays 0. Then in OPEN, pulse moving=1 -> fault=1 from the next edge and remains after moving=0, until rst_n=0.
- Obstruction while open: assert obstruction for 1 cycle when OPEN with timer=1 -> timer=4, state stays OPEN for 5 further edges, then CLOSING.
- Reopen while closing: obstruction=1 at the first CLOSING cycle -> next edge state=OPENING, timer=1; door reaches OPEN 2 edges later.
- Early close and mid-op reset:
  - close_req=1 at OPEN with timer=3 -> CLOSING next edge, timer=1.
  - rst_n=0 during CLOSING -> CLOSED, timer=0 on that edge.
